// File: rtl/parity_sweep_ctrl.sv
// Exhaustive sweep sequencer for the 9-bit parity checker.
// Steps the counter through all 512 vectors and scores the checker outputs.
module parity_sweep_ctrl #(
    parameter int SETTLE_CYC = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       start,
    input  logic [8:0] cnt_value,
    input  logic       dut_even,
    input  logic       dut_odd,
    output logic       cnt_enable,
    output logic       cnt_clear,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_count,
    output logic [8:0] first_err_vec,
    output logic       first_err_valid,
    output logic       seq_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_STEP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [3:0] SETTLE = SETTLE_CYC[3:0];

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [3:0] settle;
    logic [8:0] vec_idx;
    logic       exp_even;
    logic       mismatch;
    logic       last_vec;
    logic [9:0] err_nxt;
    logic       seq_nxt;

    assign exp_even = ~^cnt_value;
    assign mismatch = (dut_even != exp_even) || (dut_odd != ~exp_even);
    assign last_vec = (vec_idx == 9'd511);

    always_comb begin
        err_nxt = err_count;
        if (mismatch && err_count != 10'h3FF)
            err_nxt = err_count + 10'd1;
        seq_nxt = seq_err | (cnt_value != vec_idx);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_CLR;
            S_CLR:          state_nxt = S_WAIT;
            S_WAIT:         if (settle <= 4'd1) state_nxt = S_CHECK;
            S_CHECK:        state_nxt = last_vec ? S_DONE : S_STEP;
            S_STEP:         state_nxt = S_WAIT;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // Strobes and status are registered from the next state so they are glitch-free.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state           <= S_IDLE;
            settle          <= 4'd0;
            vec_idx         <= 9'd0;
            cnt_enable      <= 1'b0;
            cnt_clear       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= 10'd0;
            first_err_vec   <= 9'd0;
            first_err_valid <= 1'b0;
            seq_err         <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt_clear  <= (state_nxt == S_CLR);
            cnt_enable <= (state_nxt == S_STEP);
            done       <= (state_nxt == S_DONE);
            busy       <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        vec_idx         <= 9'd0;
                        pass            <= 1'b0;
                        err_count       <= 10'd0;
                        first_err_vec   <= 9'd0;
                        first_err_valid <= 1'b0;
                        seq_err         <= 1'b0;
                    end
                end
                S_CLR:  settle <= SETTLE;
                S_WAIT: settle <= settle - 4'd1;
                S_CHECK: begin
                    err_count <= err_nxt;
                    seq_err   <= seq_nxt;
                    if (mismatch && !first_err_valid) begin
                        first_err_vec   <= cnt_value;
                        first_err_valid <= 1'b1;
                    end
                    if (last_vec)
                        pass <= (err_nxt == 10'd0) && !seq_nxt;
                end
                S_STEP: begin
                    vec_idx <= vec_idx + 9'd1;
                    settle  <= SETTLE;
                end
                default: ;
            endcase
        end
    end

endmodule
